// File: rtl/vga_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : vga_pkg                                                    |
// | Purpose  : State encoding and default timing constants for the VGA    |
// |            PLL sequencer and the video timing generator.              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package vga_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } vga_pll_state_t;

    localparam int c_REFCLK_HZ     = 50_000_000;
    localparam int c_RST_CYCLES    = 16;
    localparam int c_LOCK_TIMEOUT  = 50_000;
    localparam int c_STABLE_CYCLES = 1024;
    localparam int c_MAX_RETRIES   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sync_2ff                                                   |
// | Purpose  : Two-flop single-bit synchronizer, async active-low reset.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_pll_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : vga_pll_ctrl                                               |
// | Purpose  : PLL reset/lock sequencer with timeout, retries and a       |
// |            stable-lock interval before releasing the video reset.     |
// |            Define VGA_PLL_CTRL_STATS_EN to build the loss counter.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module vga_pll_ctrl
    import vga_pkg::*;
#(
    parameter int RST_CYCLES    = c_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = c_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = c_STABLE_CYCLES,
    parameter int MAX_RETRIES   = c_MAX_RETRIES,
    parameter int CNT_W         = 8
)(
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic [2:0]       state,
    output logic             fail,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int c_TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam int c_RTY_W   = $clog2(MAX_RETRIES) + 1;

    vga_pll_state_t     r_state;
    vga_pll_state_t     w_next_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_RTY_W-1:0] r_retry;
    logic [c_RTY_W-1:0] w_next_retry;
    logic [c_RTY_W-1:0] w_retry_inc;
    logic               w_tmr_clr;
    logic               w_locked_s;
    logic               r_pll_rst;
    logic               r_sys_rst_n;
    logic               r_fail;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        w_retry_inc  = r_retry + c_RTY_W'(1);
        if (restart) begin
            w_next_state = HOLD;
            w_next_retry = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_tmr == c_TMR_W'(RST_CYCLES - 1))
                        w_next_state = WAIT;
                end
                WAIT: begin
                    if (w_locked_s) begin
                        w_next_state = STABLE;
                    end else if (r_tmr == c_TMR_W'(LOCK_TIMEOUT - 1)) begin
                        w_next_retry = w_retry_inc;
                        w_next_state = (w_retry_inc >= c_RTY_W'(MAX_RETRIES)) ? FAIL : HOLD;
                    end
                end
                STABLE: begin
                    if (!w_locked_s) begin
                        w_next_retry = w_retry_inc;
                        w_next_state = (w_retry_inc >= c_RTY_W'(MAX_RETRIES)) ? FAIL : HOLD;
                    end else if (r_tmr == c_TMR_W'(STABLE_CYCLES - 1)) begin
                        w_next_retry = '0;
                        w_next_state = RUN;
                    end
                end
                // Lock loss from RUN re-sequences without spending a retry.
                RUN: begin
                    if (!w_locked_s)
                        w_next_state = HOLD;
                end
                FAIL:    w_next_state = FAIL;
                default: w_next_state = HOLD;
            endcase
        end
        w_tmr_clr = restart || (w_next_state != r_state);
    end

    // Outputs decode the next state so they move on the same edge as state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HOLD;
            r_tmr       <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_retry     <= w_next_retry;
            r_pll_rst   <= (w_next_state == HOLD) || (w_next_state == FAIL);
            r_sys_rst_n <= (w_next_state == RUN);
            r_fail      <= (w_next_state == FAIL);
            if (w_tmr_clr)
                r_tmr <= '0;
            else if ((r_state == HOLD) || (r_state == WAIT) || (r_state == STABLE))
                r_tmr <= r_tmr + c_TMR_W'(1);
        end
    end

`ifdef VGA_PLL_CTRL_STATS_EN
    logic             w_loss_evt;
    logic [CNT_W-1:0] r_loss_cnt;

    assign w_loss_evt = (r_state == RUN) && !w_locked_s && !restart;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            r_loss_cnt <= '0;
        else if (w_loss_evt && (r_loss_cnt != {CNT_W{1'b1}}))
            r_loss_cnt <= r_loss_cnt + CNT_W'(1);
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = '0;
`endif

    assign state     = r_state;
    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign fail      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_vga_pll_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_vga_pll_ctrl                                            |
// | Purpose  : Directed self-checking bench for vga_pll_ctrl.             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_vga_pll_ctrl;
    import vga_pkg::*;

    localparam int c_RST = 4;
    localparam int c_TO  = 20;
    localparam int c_ST  = 8;
    localparam int c_MR  = 2;
    localparam int c_CW  = 2;

    logic            refclk = 1'b0;
    logic            rst_n;
    logic            restart;
    logic            pll_locked;
    logic            pll_rst;
    logic            sys_rst_n;
    logic [2:0]      state;
    logic            fail;
    logic [c_CW-1:0] loss_cnt;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic           locked;
        int             n;
        vga_pll_state_t st;
        logic           prst;
        logic           srst;
        logic           fl;
    } vec_t;

    vec_t vecs [7];

    vga_pll_ctrl #(
        .RST_CYCLES    (c_RST),
        .LOCK_TIMEOUT  (c_TO),
        .STABLE_CYCLES (c_ST),
        .MAX_RETRIES   (c_MR),
        .CNT_W         (c_CW)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .restart    (restart),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .state      (state),
        .fail       (fail),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string name, input vga_pll_state_t st,
                              input logic prst, input logic srst, input logic fl);
        check({name, ".state"},     int'(state),     int'(st));
        check({name, ".pll_rst"},   int'(pll_rst),   int'(prst));
        check({name, ".sys_rst_n"}, int'(sys_rst_n), int'(srst));
        check({name, ".fail"},      int'(fail),      int'(fl));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_state(input string name, input vga_pll_state_t st, input int budget);
        int cyc;
        cyc = 0;
        while ((state != st) && (cyc < budget)) begin
            tick(1);
            cyc++;
        end
        check({name, ".reached"}, int'(state), int'(st));
    endtask

    function automatic int exp_loss(input int drops);
`ifdef VGA_PLL_CTRL_STATS_EN
        return (drops > 3) ? 3 : drops;
`else
        return (drops > 0) ? 0 : 0;
`endif
    endfunction

    function automatic vga_pll_state_t never_lock_state(input int k);
        if (k < 4)  return HOLD;
        if (k < 24) return WAIT;
        if (k < 28) return HOLD;
        if (k < 48) return WAIT;
        return FAIL;
    endfunction

    initial begin
        vga_pll_state_t es;

        // Edge numbers are counted from rst_n release; lock driven after edge 10.
        vecs[0] = '{1'b0, 3, HOLD,   1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1, WAIT,   1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 6, WAIT,   1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2, WAIT,   1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1, STABLE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 7, STABLE, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1, RUN,    1'b0, 1'b1, 1'b0};

        rst_n      = 1'b0;
        restart    = 1'b0;
        pll_locked = 1'b0;
        tick(3);
        check_outs("reset", HOLD, 1'b1, 1'b0, 1'b0);
        check("reset.loss_cnt", int'(loss_cnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            pll_locked = vecs[i].locked;
            tick(vecs[i].n);
            check_outs($sformatf("powerup[%0d]", i), vecs[i].st, vecs[i].prst,
                       vecs[i].srst, vecs[i].fl);
        end
        check("powerup.loss_cnt", int'(loss_cnt), 0);

        for (int d = 1; d <= 5; d++) begin
            pll_locked = 1'b0;
            tick(2);
            check($sformatf("drop%0d.pre_sys_rst_n", d), int'(sys_rst_n), 1);
            tick(1);
            check_outs($sformatf("drop%0d", d), HOLD, 1'b1, 1'b0, 1'b0);
            check($sformatf("drop%0d.loss_cnt", d), int'(loss_cnt), exp_loss(d));
            pll_locked = 1'b1;
            wait_state($sformatf("drop%0d.relock", d), RUN, 40);
        end

        // Restart lands on the same edge the FSM would act on the loss.
        pll_locked = 1'b0;
        tick(2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check_outs("restart_drop", HOLD, 1'b1, 1'b0, 1'b0);
        check("restart_drop.loss_cnt", int'(loss_cnt), exp_loss(5));
        tick(3);
        check("restart_drop.hold3", int'(state), int'(HOLD));
        tick(1);
        check("restart_drop.wait", int'(state), int'(WAIT));

        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            es = never_lock_state(k);
            check($sformatf("nolock[%0d].state", k), int'(state), int'(es));
            check($sformatf("nolock[%0d].pll_rst", k), int'(pll_rst),
                  ((es == HOLD) || (es == FAIL)) ? 1 : 0);
        end
        check_outs("fail_hold", FAIL, 1'b1, 1'b0, 1'b1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check_outs("fail_restart", HOLD, 1'b1, 1'b0, 1'b0);

        pll_locked = 1'b1;
        wait_state("glitch.stable", STABLE, 30);
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("glitch.cnt5_stable", int'(state), int'(STABLE));
        tick(1);
        check_outs("glitch.hold", HOLD, 1'b1, 1'b0, 1'b0);
        check("glitch.retry", int'(dut.r_retry), 1);
        tick(4);
        check("glitch.wait", int'(state), int'(WAIT));
        tick(1);
        check("glitch.stable2", int'(state), int'(STABLE));
        tick(7);
        check_outs("glitch.stable_end", STABLE, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_outs("glitch.run", RUN, 1'b0, 1'b1, 1'b0);
        check("glitch.retry_clr", int'(dut.r_retry), 0);

        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        wait_state("arst.stable", STABLE, 30);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("arst", HOLD, 1'b1, 1'b0, 1'b0);
        check("arst.loss_cnt", int'(loss_cnt), 0);
        check("arst.retry", int'(dut.r_retry), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("arst.after", int'(state), int'(HOLD));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vga_pll_ctrl.md
# vga_pll_ctrl

Reset and lock sequencer for the VGA pixel-clock PLL. Runs in the 50 MHz reference domain. Holds the PLL in reset at power-up and waits for lock with a timeout and bounded retries. It releases the downstream video reset only after lock has been stable for a programmable interval, and re-sequences automatically on lock loss.

## Interface
- RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1)
- LOCK_TIMEOUT, 50000: cycles to wait for lock per attempt (1 ms at 50 MHz)
- STABLE_CYCLES, 1024: cycles lock must persist before release (≥1)
- MAX_RETRIES, 4: consecutive failed attempts before FAIL (≥1)
- CNT_W, 8: width of `loss_cnt`
- refclk  in  1  reference clock, 50 MHz; sole clock
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous one-cycle pulse; forces a new sequence
- pll_locked  in  1  PLL lock flag, asynchronous to `refclk`
- pll_rst  out  1  active-high reset to the PLL `rst` input
- sys_rst_n  out  1  active-low downstream reset; high only in RUN
- state  out  3  current FSM state encoding
- fail  out  1  high in FAIL
- loss_cnt  out  CNT_W  saturating count of lock losses from RUN

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. Nothing else samples the raw input.
- One shared cycle counter, width `$clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))`, clears on every state change. Retry counter is `$clog2(MAX_RETRIES)+1` bits.
- States and transitions:
  - HOLD: `pll_rst`=1. When counter==RST_CYCLES-1, go to WAIT.
  - WAIT: `pll_rst`=0.
    - If `locked_s`=1, go to STABLE.
    - Else, when counter==LOCK_TIMEOUT-1: retry++. Go to FAIL if retry reaches MAX_RETRIES, otherwise go to HOLD.
  - STABLE: if `locked_s`=0, retry++ and go to HOLD (or to FAIL at MAX_RETRIES). Else, when counter==STABLE_CYCLES-1, go to RUN and clear retry.
  - RUN: `sys_rst_n`=1. If `locked_s`=0, go to HOLD and increment `loss_cnt` (saturates at all-ones; no wrap).
  - FAIL: `pll_rst`=1, `fail`=1. Exits only on `restart` or `rst_n`.
- `restart` takes priority over every transition in every state. It goes to HOLD, clears the cycle and retry counters, and does not touch `loss_cnt`.
- Lock loss in RUN and a `restart` in the same cycle: `restart` wins and `loss_cnt` is unchanged.
- Lock loss does not consume a retry in RUN. Retries count only failed attempts from WAIT/STABLE.

## Timing
- Reset values: state=HOLD, `pll_rst`=1, `sys_rst_n`=0, `fail`=0, `loss_cnt`=0, all counters 0.
- All outputs are registered and decoded from the next state, so each output changes in the same cycle as `state`.
- Rise of `pll_locked` at edge t gives `locked_s`=1 at t+2, and STABLE at t+3 when in WAIT.
- RUN begins STABLE_CYCLES cycles after STABLE entry. `sys_rst_n` rises that cycle.
- Fall of `pll_locked` in RUN gives `sys_rst_n`=0 and `pll_rst`=1 three edges later (2 sync + 1 FSM).
- Minimum power-up to release: RST_CYCLES + lock latency + 2 + 1 + STABLE_CYCLES.
- `rst_n` assertion mid-sequence forces reset values immediately, asynchronously. Deassertion is synchronized externally.
- Consumers in the pixel domain re-synchronize `sys_rst_n`. This block guarantees only glitch-free, registered output.

## Configuration
- `VGA_PLL_CTRL_STATS_EN`: when defined, `loss_cnt` is implemented as specified.
- When undefined, `loss_cnt` is tied to 0, its counter is removed, and FSM behaviour is identical.

## Structure
- Package `vga_pkg`:
  - state typedef `vga_pll_state_t`: HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.
  - default timing constants shared with the timing generator.
- Sub-module `sync_2ff`: 2-flop synchronizer with async active-low reset to 0. It is reused for the `sys_rst_n` crossing elsewhere.

## Test plan
Parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up, `pll_locked` rises 10 cycles after `rst_n` release:
  - `pll_rst` high for exactly 4 cycles.
  - `sys_rst_n` rises 8 cycles after STABLE entry.
  - `fail`=0.
- `pll_locked` never rises:
  - two 4-cycle HOLD pulses each followed by 20 WAIT cycles.
  - then FAIL with `fail`=1, `pll_rst`=1, held indefinitely.
  - `restart` pulse returns to HOLD with `fail`=0.
- Lock glitch of 1 cycle at STABLE counter=5: return to HOLD, retry=1. Next clean lock reaches RUN and retry clears to 0.
- Three lock drops in RUN: `loss_cnt`=3, `sys_rst_n`=0 three edges after each drop. With CNT_W=2 and five drops, `loss_cnt` saturates at 3.
- `restart` coinciding with a lock drop in RUN: state goes to HOLD and `loss_cnt` is unchanged.
- `rst_n` asserted during STABLE: all outputs return to reset values in the same cycle. Build without `VGA_PLL_CTRL_STATS_EN`: `loss_cnt`=0 throughout.
